poly_mod_sub_ctrl: RTL

// - Sequences one coefficient-wise polynomial subtraction out = (A - B) mod q over 2^N_LOG coefficients.
// - Streams A and B from two synchronous-read RAM ports through one mod_sub instance.
// - Writes results to a third RAM port.
// - Sits between the top-level command decoder and the polynomial BRAM banks.
// - Issues one coefficient per cycle, fully pipelined, with no stalls.

---
 rtl/fhe_acc_pkg.sv | 16 +
 rtl/poly_mod_sub_ctrl_if.sv | 28 ++
 rtl/mod_sub.sv | 23 ++
 rtl/poly_mod_sub_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fhe_acc_pkg.sv
// Shared types for the FHE accelerator controllers that sequence polynomial
// operations between the command decoder and the coefficient BRAM banks.
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif

package fhe_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } ctrl_state_e;

endpackage

// File: rtl/poly_mod_sub_ctrl_if.sv
// Command and BRAM-side signals of the polynomial subtraction controller.
// The slave side is the controller; the master side is the decoder/RAM fabric.
interface poly_mod_sub_ctrl_if #(
  parameter int N_LOG = 10,
  parameter int BW    = `BIT_WIDTH
);
  logic             start;
  logic [BW-1:0]    q_in;
  logic             busy;
  logic             done;
  logic [N_LOG-1:0] rd_addr;
  logic             rd_en;
  logic [BW-1:0]    a_rdata;
  logic [BW-1:0]    b_rdata;
  logic [N_LOG-1:0] wr_addr;
  logic             wr_en;
  logic [BW-1:0]    wr_data;

  modport master (
    output start, q_in, a_rdata, b_rdata,
    input  busy, done, rd_addr, rd_en, wr_addr, wr_en, wr_data
  );

  modport slave (
    input  start, q_in, a_rdata, b_rdata,
    output busy, done, rd_addr, rd_en, wr_addr, wr_en, wr_data
  );
endinterface

// File: rtl/mod_sub.sv
// Combinational modular subtraction r = (a - b) mod q for operands already in [0, q).
module mod_sub #(
  parameter int BW = `BIT_WIDTH
) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] q,
  output logic [BW-1:0] r
);

  // A negative difference lies in (-q, 0); adding q in BW-bit arithmetic lands
  // exactly in [0, q) because the carry out of the sign bit is discarded.
  function automatic logic [BW-1:0] wrap_mod(input logic signed [BW:0] d,
                                             input logic [BW-1:0]     m);
    return d[BW] ? d[BW-1:0] + m : d[BW-1:0];
  endfunction

  logic signed [BW:0] diff;

  assign diff = $signed({1'b0, a}) - $signed({1'b0, b});
  assign r    = wrap_mod(diff, q);

endmodule

// File: rtl/poly_mod_sub_ctrl.sv
// Streams A and B through one mod_sub, one coefficient per cycle, and writes
// (A - B) mod q back to the result bank, pulsing done after the last write.
module poly_mod_sub_ctrl
  import fhe_acc_pkg::*;
#(
  parameter int N_LOG  = 10,
  parameter int RD_LAT = 2
) (
  input logic               clk,
  input logic               rstn,
  poly_mod_sub_ctrl_if.slave bus
);

  localparam int BW = `BIT_WIDTH;
  localparam logic [N_LOG-1:0] LAST_ADDR = '1;

  ctrl_state_e      state_q, state_d;
  logic [N_LOG:0]   cnt_q, cnt_d;
  logic [BW-1:0]    q_lat_q, q_lat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [N_LOG-1:0] rd_addr_q, rd_addr_d;
  logic             wr_en_q, wr_en_d;
  logic [N_LOG-1:0] wr_addr_q, wr_addr_d;
  logic [BW-1:0]    wr_data_q, wr_data_d;
  logic [BW-1:0]    sub_res;

  logic             dl_vld_q  [RD_LAT];
  logic             dl_vld_d  [RD_LAT];
  logic [N_LOG-1:0] dl_addr_q [RD_LAT];
  logic [N_LOG-1:0] dl_addr_d [RD_LAT];

  mod_sub #(.BW(BW)) u_mod_sub (
    .a (bus.a_rdata),
    .b (bus.b_rdata),
    .q (q_lat_q),
    .r (sub_res)
  );

  // Read-tag delay line: the last stage lines up with the RAM data.
  for (genvar i = 0; i < RD_LAT; i++) begin : g_dl
    if (i == 0) begin : g_head
      assign dl_vld_d[i]  = rd_en_q;
      assign dl_addr_d[i] = rd_addr_q;
    end else begin : g_tail
      assign dl_vld_d[i]  = dl_vld_q[i-1];
      assign dl_addr_d[i] = dl_addr_q[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_lat_d   = q_lat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE: begin
        // Address 0 is issued on the accepting edge, so the counter holds
        // the number of reads already issued.
        if (bus.start) begin
          state_d   = ISSUE;
          q_lat_d   = bus.q_in;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          cnt_d     = {{N_LOG{1'b0}}, 1'b1};
        end
      end
      ISSUE: begin
        if (cnt_q[N_LOG]) begin
          state_d = DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = cnt_q[N_LOG-1:0];
          cnt_d     = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    wr_en_d   = dl_vld_q[RD_LAT-1];
    wr_addr_d = dl_vld_q[RD_LAT-1] ? dl_addr_q[RD_LAT-1] : wr_addr_q;
    wr_data_d = dl_vld_q[RD_LAT-1] ? sub_res : wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      q_lat_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      dl_vld_q  <= '{default: 1'b0};
      dl_addr_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_lat_q   <= q_lat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      dl_vld_q  <= dl_vld_d;
      dl_addr_q <= dl_addr_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule
